// File: rtl/spi_oled_rx_monitor.sv
// spi_oled_rx_monitor: oversampled SPI mode-0 byte receiver with D/C tagging, FIFO and sticky status.
// Define SPI_OLED_RX_ECHO_EN to echo the previously completed byte on spi_miso.
module spi_oled_rx_monitor #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             spi_cs,
    input  logic             spi_clk,
    input  logic             spi_mosi,
    input  logic             oled_dc,
    output logic [7:0]       rx_data,
    output logic             rx_is_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    input  logic             clr_status,
    output logic             overflow,
    output logic             frame_err,
    output logic [CNT_W-1:0] rx_count,
    output logic             spi_miso
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic {IDLE, SHIFT} state_t;

    logic [2:0]       cs_q, sclk_q;
    logic [1:0]       mosi_q, dc_q;
    state_t           state_q;
    logic [2:0]       cnt_q;
    logic [6:0]       sh_q;
    logic [8:0]       mem_q [FIFO_DEPTH];
    logic [AW:0]      wr_q, rd_q;
    logic             overflow_q, frame_err_q;
    logic [CNT_W-1:0] count_q;

    logic cs_s, cs_rise, sclk_rise, byte_done, ferr_set;
    logic full, empty, pop, push_ok, ovf_set;

    assign cs_s      = cs_q[1];
    assign cs_rise   = cs_q[1] & ~cs_q[2];
    assign sclk_rise = sclk_q[1] & ~sclk_q[2];
    assign byte_done = (state_q == SHIFT) && !cs_s && sclk_rise && (cnt_q == 3'd7);
    assign ferr_set  = (state_q == SHIFT) && cs_rise && (cnt_q != 3'd0);

    assign empty    = (wr_q == rd_q);
    assign full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop      = rx_valid && rx_ready;
    assign push_ok  = byte_done && (!full || pop);
    assign ovf_set  = byte_done && full && !pop;

    assign rx_valid               = !empty;
    assign {rx_is_data, rx_data}  = mem_q[rd_q[AW-1:0]];
    assign overflow               = overflow_q;
    assign frame_err              = frame_err_q;
    assign rx_count               = count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_q   <= 3'b111;
            sclk_q <= 3'b000;
            mosi_q <= 2'b00;
            dc_q   <= 2'b00;
        end else begin
            cs_q   <= {cs_q[1:0], spi_cs};
            sclk_q <= {sclk_q[1:0], spi_clk};
            mosi_q <= {mosi_q[0], spi_mosi};
            dc_q   <= {dc_q[0], oled_dc};
        end
    end

    // SCLK edges are only honoured while CS stays low; a CS rise aborts any partial byte
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            sh_q    <= 7'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q <= 3'd0;
                    if (!cs_s) state_q <= SHIFT;
                end
                default: begin
                    if (cs_rise) begin
                        state_q <= IDLE;
                        cnt_q   <= 3'd0;
                    end else if (sclk_rise) begin
                        sh_q  <= {sh_q[5:0], mosi_q[1]};
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 9'd0;
            wr_q        <= '0;
            rd_q        <= '0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
            count_q     <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_q[AW-1:0]] <= {dc_q[1], sh_q, mosi_q[1]};
                wr_q                <= wr_q + 1'b1;
                count_q             <= count_q + 1'b1;
            end
            if (pop) rd_q <= rd_q + 1'b1;
            overflow_q  <= ovf_set | (overflow_q & ~clr_status);
            frame_err_q <= ferr_set | (frame_err_q & ~clr_status);
        end
    end

`ifdef SPI_OLED_RX_ECHO_EN
    logic [7:0] echo_q, tx_q;
    logic       cs_fall, sclk_fall;

    assign cs_fall   = ~cs_q[1] & cs_q[2];
    assign sclk_fall = ~sclk_q[1] & sclk_q[2];
    assign spi_miso  = tx_q[7];

    // at a byte boundary the falling edge reloads the shifter with the byte just completed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            echo_q <= 8'd0;
            tx_q   <= 8'd0;
        end else begin
            if (byte_done) echo_q <= {sh_q, mosi_q[1]};
            if (cs_fall) tx_q <= echo_q;
            else if (state_q == SHIFT && !cs_s && sclk_fall)
                tx_q <= (cnt_q == 3'd0) ? echo_q : {tx_q[6:0], 1'b0};
        end
    end
`else
    assign spi_miso = 1'b0;
`endif
endmodule

// File: tb/tb_spi_oled_rx_monitor.sv
// tb_spi_oled_rx_monitor: directed SPI byte stimulus with immediate-assertion checks.
module tb_spi_oled_rx_monitor;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        spi_cs = 1'b1, spi_clk = 1'b0, spi_mosi = 1'b0, oled_dc = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_is_data, rx_valid;
    logic        rx_ready = 1'b1, clr_status = 1'b0;
    logic        overflow, frame_err, spi_miso;
    logic [15:0] rx_count;

    int checks = 0;
    int failures = 0;
    logic [8:0] popq[$];
    logic [7:0] miso_byte;

    spi_oled_rx_monitor #(.FIFO_DEPTH(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .spi_cs(spi_cs), .spi_clk(spi_clk),
        .spi_mosi(spi_mosi), .oled_dc(oled_dc), .rx_data(rx_data),
        .rx_is_data(rx_is_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .clr_status(clr_status), .overflow(overflow), .frame_err(frame_err),
        .rx_count(rx_count), .spi_miso(spi_miso)
    );

    always #5 clk = ~clk;

    // capture each pop just before the posedge that performs it
    always begin
        @(negedge clk);
        #4;
        if (rst_n && rx_valid && rx_ready) popq.push_back({rx_is_data, rx_data});
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] pq(input int i);
        return (i < popq.size()) ? popq[i] : 9'bx;
    endfunction

    // clk/8 SCLK; optional one-cycle rx_ready pulse aligned to the push of the last bit
    task automatic send(input logic d, input logic [7:0] b, input int nb, input logic pulse);
        for (int i = 7; i >= 8 - nb; i--) begin
            oled_dc  = d;
            spi_mosi = b[i];
            repeat (4) @(negedge clk);
            spi_clk = 1'b1;
            miso_byte[i] = spi_miso;
            if (pulse && i == 0) begin
                repeat (2) @(negedge clk);
                rx_ready = 1'b1;
                @(negedge clk);
                rx_ready = 1'b0;
                @(negedge clk);
            end else repeat (4) @(negedge clk);
            spi_clk = 1'b0;
        end
    endtask

    task automatic open_cs();
        spi_cs = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic close_cs();
        repeat (8) @(negedge clk);
        spi_cs = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        logic [7:0] hello [5];
        hello = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F};
        repeat (3) @(negedge clk);
        chk("rst_valid", rx_valid, 0);
        chk("rst_data", rx_data, 0);
        chk("rst_isdata", rx_is_data, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_count", rx_count, 0);
        chk("rst_miso", spi_miso, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        open_cs();
        for (int i = 0; i < 5; i++) send(1'b1, hello[i], 8, 1'b0);
        close_cs();
        chk("hello_pops", popq.size(), 5);
        for (int i = 0; i < 5; i++) chk("hello_byte", pq(i), {1'b1, hello[i]});
        chk("hello_count", rx_count, 5);
        chk("hello_ovf", overflow, 0);
        chk("hello_ferr", frame_err, 0);

        open_cs();
        send(1'b0, 8'hAF, 8, 1'b0);
        send(1'b1, 8'h00, 8, 1'b0);
        close_cs();
        chk("cmd_af", pq(5), 9'h0AF);
        chk("data_00", pq(6), 9'h100);
        chk("dc_count", rx_count, 7);

        rx_ready = 1'b0;
        open_cs();
        for (int i = 1; i <= 5; i++) send(1'b1, 8'(i), 8, 1'b0);
        close_cs();
        chk("ovf_set", overflow, 1);
        chk("ovf_count", rx_count, 11);
        chk("ovf_head", {rx_valid, rx_is_data, rx_data}, 10'h301);
        rx_ready = 1'b1;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 4; i++) chk("ovf_drain", pq(7 + i), 9'h100 + 9'(i + 1));
        chk("ovf_empty", rx_valid, 0);
        chk("ovf_sticky", overflow, 1);
        clr_status = 1'b1;
        @(negedge clk);
        clr_status = 1'b0;
        chk("ovf_clr", overflow, 0);

        open_cs();
        send(1'b1, 8'hA5, 5, 1'b0);
        close_cs();
        chk("ferr_set", frame_err, 1);
        chk("ferr_nopush", rx_count, 11);
        chk("ferr_empty", rx_valid, 0);
        open_cs();
        send(1'b1, 8'h3C, 8, 1'b0);
        close_cs();
        chk("ferr_next", pq(11), 9'h13C);
        chk("ferr_count", rx_count, 12);
        chk("ferr_sticky", frame_err, 1);
        clr_status = 1'b1;
        @(negedge clk);
        clr_status = 1'b0;
        chk("ferr_clr", frame_err, 0);

        rx_ready = 1'b0;
        open_cs();
        for (int i = 0; i < 4; i++) send(1'b1, 8'h10 + 8'(i), 8, 1'b0);
        send(1'b1, 8'h14, 8, 1'b1);
        close_cs();
        chk("pp_ovf", overflow, 0);
        chk("pp_count", rx_count, 17);
        chk("pp_popped", pq(12), 9'h110);
        chk("pp_head", rx_data, 8'h11);
        rx_ready = 1'b1;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 4; i++) chk("pp_order", pq(13 + i), 9'h111 + 9'(i));
        chk("pp_empty", rx_valid, 0);

`ifdef SPI_OLED_RX_ECHO_EN
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        open_cs();
        send(1'b1, 8'h12, 8, 1'b0);
        chk("echo_first", miso_byte, 8'h00);
        send(1'b1, 8'h34, 8, 1'b0);
        chk("echo_second", miso_byte, 8'h12);
        close_cs();
`else
        chk("miso_const", spi_miso, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
